sr_button_conditioner: RTL and testbench
========================================

# sr_button_conditioner

Front-end stage that turns two raw, asynchronous, bouncy push-button inputs (set and reset requests) into clean, single-cycle S and R command pulses that drive the sr_flipflop directly. It synchronises each input, debounces it with a per-channel stability counter and detects the press edge. It also arbitrates so that S and R are never asserted in the same cycle, because that is the flip-flop's illegal input combination.

## Interface
- SYNC_STAGES, 2: synchroniser depth per input; legal range ≥ 2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a level change is accepted; legal range ≥ 1.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- set_btn  input  1  raw set button, asynchronous to clk.
- rst_btn  input  1  raw reset button, asynchronous to clk.
- S  output  1  one-cycle set command to sr_flipflop.S.
- R  output  1  one-cycle reset command to sr_flipflop.R.
- set_level  output  1  debounced level of set_btn.
- rst_level  output  1  debounced level of rst_btn.
- conflict  output  1  one-cycle flag: simultaneous press edges were suppressed.

## Operation
- Per channel, a SYNC_STAGES-deep flop chain produces the synchronised input, sync.
- Debounce:
  - Counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - On any edge where sync equals the debounced level, cnt is cleared to 0.
  - Otherwise cnt increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching edge, the debounced level toggles and cnt clears.
- Edge detect: a 0→1 transition of the debounced level raises a one-edge press request for that channel. A 1→0 transition (release) produces nothing.
- Arbitration, evaluated each cycle:
  - Only set request: S=1.
  - Only reset request: R=1.
  - Both requests: S=0, R=0, conflict=1; both requests are dropped, not queued.
- Holding one button while pressing the other is legal. Only press edges matter, so the new press produces its own pulse.
- Invariant: S & R == 0 in every cycle, including the cycle reset deasserts.

## Timing
- Reset values: S=0, R=0, conflict=0, set_level=0, rst_level=0; all sync flops and counters 0.
- Latency:
  - Edge k is the first rising edge that samples a new stable level on a button.
  - The matching pulse (S or R) is high for the cycle following edge k+SYNC_STAGES+DEBOUNCE_CYCLES, and low again after the next edge.
  - Defaults: pulse after edge k+6.
- The debounced level (set_level/rst_level) changes one edge before the pulse. All outputs are registered.
- Glitch rejection: a level that reverts at sync before DEBOUNCE_CYCLES consecutive mismatching edges yields no level change and no pulse.
- Pulse width is always exactly one cycle, regardless of press duration.
- Reset mid-debounce: all partial counts are discarded.
- Button held through reset release: the debounced level restarts at 0, so the held button is re-debounced and produces one pulse after the full latency, measured from the first edge after release.
- Conflict window: edges count as simultaneous only if both press requests land on the same edge. Edges one cycle apart yield S then R, or R then S, on consecutive cycles.

## Structure
- Package sr_cond_pkg:
  - default parameter constants;
  - typedef for the channel record {sync, level, cnt};
  - counter-width function wrapping $clog2(DEBOUNCE_CYCLES+1).
- Sub-module sr_debounce_channel (synchroniser + counter + level + press-edge output), instantiated twice.
- The top level holds only the arbitration and output registers.

## Test plan
- Reset asserted with both buttons 0, then released → all outputs 0; no pulses for 20 cycles.
- Clean set_btn press held 10 cycles (defaults) → set_level rises after edge k+5; S=1 for exactly one cycle after edge k+6; R and conflict stay 0; release → no pulse.
- set_btn bounce 1-0-1-0 at single-cycle spacing, then stable 1 → no pulse during bounce; exactly one S pulse, 6 edges after the last transition sampled.
- set_btn and rst_btn rise on the same edge → conflict=1 for one cycle; S=0 and R=0 throughout; both levels go to 1.
- rst_btn rises one cycle after set_btn → S pulse, then R pulse on the next cycle; never both high.
- Reset asserted asynchronously mid-debounce with set_btn held, then released → all outputs 0 immediately; S pulses once, SYNC_STAGES+DEBOUNCE_CYCLES edges after release.

Source files
------------

// File: rtl/sr_button_conditioner_pkg.sv
// Shared definitions for the S/R button conditioner.
// Contents: default parameter values, the debounce counter width helper,
// and the per-channel state record {sync, level, cnt} at default sizing.
package sr_cond_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Counter must be able to hold DEBOUNCE_CYCLES itself.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

    // Channel record at default sizing; the channel module builds the same
    // layout from its own parameters.
    typedef struct packed {
        logic [SYNC_STAGES_DEF-1:0] sync;
        logic                       level;
        logic [CNT_W_DEF-1:0]       cnt;
    } chan_rec_t;

endpackage

// File: rtl/sr_button_conditioner_if.sv
// Button/command bundle between the raw button source and the conditioner.
// master: drives set_btn/rst_btn, observes S, R, levels and conflict.
// slave : the conditioner; consumes the buttons, produces the commands.
interface sr_button_conditioner_if;
    logic set_btn;
    logic rst_btn;
    logic S;
    logic R;
    logic set_level;
    logic rst_level;
    logic conflict;

    modport master (
        output set_btn, rst_btn,
        input  S, R, set_level, rst_level, conflict
    );

    modport slave (
        input  set_btn, rst_btn,
        output S, R, set_level, rst_level, conflict
    );
endinterface

// File: rtl/sr_button_conditioner_channel.sv
// One button channel: synchroniser chain, stability-counter debounce and
// press-edge detection.
// Ports: clk, reset (async active-high), btn (raw async input),
//        level (debounced level, registered), press (high for one cycle
//        after the debounced level rises).
module sr_debounce_channel
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [SYNC_STAGES-1:0] sync;
        logic                   level;
        logic [CNT_W-1:0]       cnt;
    } chan_t;

    chan_t ch_r;
    chan_t ch_s;
    logic  level_d_r;

    // Next state: shift the synchroniser, then run the stability counter
    // against the last synchroniser stage.
    always_comb begin
        ch_s      = ch_r;
        ch_s.sync = {ch_r.sync[SYNC_STAGES-2:0], btn};
        if (ch_r.sync[SYNC_STAGES-1] == ch_r.level) begin
            ch_s.cnt = '0;
        end else if (ch_r.cnt == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive mismatch.
            ch_s.level = ~ch_r.level;
            ch_s.cnt   = '0;
        end else begin
            ch_s.cnt = ch_r.cnt + CNT_ONE;
        end
    end

    // Channel state and delayed level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_r      <= '0;
            level_d_r <= 1'b0;
        end else begin
            ch_r      <= ch_s;
            level_d_r <= ch_r.level;
        end
    end

    assign level = ch_r.level;
    // Both terms are registered, so press is glitch-free into the arbiter.
    assign press = ch_r.level & ~level_d_r;

endmodule

// File: rtl/sr_button_conditioner.sv
// Turns two raw bouncy buttons into clean one-cycle S/R commands for an
// SR flip-flop, never asserting S and R together.
// Ports: clk, reset (async active-high), bus (slave modport: set_btn,
//        rst_btn in; S, R, set_level, rst_level, conflict out).
module sr_button_conditioner
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    sr_button_conditioner_if.slave     bus
);

    logic set_press_s;
    logic rst_press_s;
    logic s_s;
    logic r_s;
    logic conflict_s;
    logic s_r;
    logic r_r;
    logic conflict_r;

    sr_debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set_ch (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.set_btn),
        .level (bus.set_level),
        .press (set_press_s)
    );

    sr_debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rst_ch (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.rst_btn),
        .level (bus.rst_level),
        .press (rst_press_s)
    );

    // Arbitration: simultaneous presses are dropped and flagged.
    always_comb begin
        s_s        = 1'b0;
        r_s        = 1'b0;
        conflict_s = 1'b0;
        case ({set_press_s, rst_press_s})
            2'b10:   s_s        = 1'b1;
            2'b01:   r_s        = 1'b1;
            2'b11:   conflict_s = 1'b1;
            default: begin
                s_s        = 1'b0;
                r_s        = 1'b0;
                conflict_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            s_r        <= s_s;
            r_r        <= r_s;
            conflict_r <= conflict_s;
        end
    end

    assign bus.S        = s_r;
    assign bus.R        = r_r;
    assign bus.conflict = conflict_r;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Self-checking bench for sr_button_conditioner at default parameters.
// Expected pulses are queued with the edge count at which they must be
// visible; a negedge monitor pops and compares them, expecting zeros on
// every other cycle.
module tb_sr_button_conditioner;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    sr_button_conditioner_if bif ();

    sr_button_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Pulse scoreboard: exactly the queued pulses, nothing else.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
            end else begin
                mon_e = '{cyc, 1'b0, 1'b0, 1'b0};
            end
            check_eq("S", {31'd0, bif.S}, {31'd0, mon_e.s});
            check_eq("R", {31'd0, bif.R}, {31'd0, mon_e.r});
            check_eq("conflict", {31'd0, bif.conflict}, {31'd0, mon_e.c});
            check_eq("S_and_R", {31'd0, bif.S & bif.R}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Wait for the negedge following edge t (bounded).
    task automatic at_neg(input int t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc >= t) break;
        end
        check_eq("wait_edge", cyc, t);
    endtask

    task automatic push(input int c, input logic s, input logic r, input logic k);
        exp_q.push_back('{c, s, r, k});
    endtask

    int n;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        mon_en      = 1'b0;
        reset       = 1'b1;
        bif.set_btn = 1'b0;
        bif.rst_btn = 1'b0;

        // Reset with buttons idle.
        idle(2);
        check_eq("rst_S", {31'd0, bif.S}, 32'd0);
        check_eq("rst_R", {31'd0, bif.R}, 32'd0);
        check_eq("rst_conflict", {31'd0, bif.conflict}, 32'd0);
        check_eq("rst_set_level", {31'd0, bif.set_level}, 32'd0);
        check_eq("rst_rst_level", {31'd0, bif.rst_level}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(20);

        // Clean set press held 10 cycles, then release.
        bif.set_btn = 1'b1;
        n = cyc;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        at_neg(n + 5);
        check_eq("clean_lvl_early", {31'd0, bif.set_level}, 32'd0);
        at_neg(n + 6);
        check_eq("clean_lvl", {31'd0, bif.set_level}, 32'd1);
        check_eq("clean_rlvl", {31'd0, bif.rst_level}, 32'd0);
        idle(4);
        bif.set_btn = 1'b0;
        n = cyc;
        at_neg(n + 6);
        check_eq("release_lvl", {31'd0, bif.set_level}, 32'd0);
        idle(6);

        // Bounce 1-0-1-0 then stable 1.
        bif.set_btn = 1'b1; step();
        bif.set_btn = 1'b0; step();
        bif.set_btn = 1'b1; step();
        bif.set_btn = 1'b0; step();
        bif.set_btn = 1'b1;
        n = cyc;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        at_neg(n + 5);
        check_eq("bounce_lvl_early", {31'd0, bif.set_level}, 32'd0);
        at_neg(n + 6);
        check_eq("bounce_lvl", {31'd0, bif.set_level}, 32'd1);
        idle(4);
        bif.set_btn = 1'b0;
        idle(12);

        // Simultaneous presses: conflict only.
        bif.set_btn = 1'b1;
        bif.rst_btn = 1'b1;
        n = cyc;
        push(n + 7, 1'b0, 1'b0, 1'b1);
        at_neg(n + 6);
        check_eq("conf_slvl", {31'd0, bif.set_level}, 32'd1);
        check_eq("conf_rlvl", {31'd0, bif.rst_level}, 32'd1);
        idle(5);
        bif.set_btn = 1'b0;
        bif.rst_btn = 1'b0;
        idle(12);

        // Reset press one cycle after set press: S then R.
        bif.set_btn = 1'b1;
        n = cyc;
        step();
        bif.rst_btn = 1'b1;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        push(n + 8, 1'b0, 1'b1, 1'b0);
        idle(10);
        bif.set_btn = 1'b0;
        bif.rst_btn = 1'b0;
        idle(12);

        // Reset asserted mid-debounce with rst_level high and set held.
        bif.rst_btn = 1'b1;
        n = cyc;
        push(n + 7, 1'b0, 1'b1, 1'b0);
        idle(8);
        check_eq("pre_rlvl", {31'd0, bif.rst_level}, 32'd1);
        bif.set_btn = 1'b1;
        idle(3);
        reset       = 1'b1;
        bif.rst_btn = 1'b0;
        #1;
        check_eq("arst_rlvl", {31'd0, bif.rst_level}, 32'd0);
        check_eq("arst_slvl", {31'd0, bif.set_level}, 32'd0);
        check_eq("arst_S", {31'd0, bif.S}, 32'd0);
        idle(2);
        reset = 1'b0;
        n = cyc;
        push(n + 7, 1'b1, 1'b0, 1'b0);
        at_neg(n + 5);
        check_eq("post_rst_lvl_early", {31'd0, bif.set_level}, 32'd0);
        at_neg(n + 6);
        check_eq("post_rst_lvl", {31'd0, bif.set_level}, 32'd1);
        idle(4);
        bif.set_btn = 1'b0;
        idle(15);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
